// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the DMEM port arbiter.
// Optional fault checking in the top level is enabled by DMEM_ARB_FAULT_CHECK_EN.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    // funct3 size codes
    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    // Address width held in the command register; the top-level AW must not exceed it.
    localparam int unsigned CMD_AW = 32;

    typedef struct packed {
        logic              we;
        logic [2:0]        size;
        logic [CMD_AW-1:0] addr;
        logic [31:0]       wdata;
    } cmd_t;

    // Bytes touched by an access; 0 for illegal codes (they fault separately).
    function automatic logic [2:0] size_bytes(input logic [2:0] size);
        logic [2:0] n;
        case (size)
            SZ_B, SZ_BU: n = 3'd1;
            SZ_H, SZ_HU: n = 3'd2;
            SZ_W:        n = 3'd4;
            default:     n = 3'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/dmem_rr_pick.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the port
// that did not win last time. Purely combinational.
module dmem_rr_pick (
    input  logic [1:0] i_req,
    input  logic       i_last_grant,
    output logic       o_valid,
    output logic       o_grant
);

    // Resolve the winner from the current requests and the previous grant.
    always_comb begin
        o_valid = |i_req;
        o_grant = 1'b0;
        if (i_req == 2'b11) begin
            o_grant = ~i_last_grant;
        end else begin
            o_grant = i_req[1];
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the byte-addressed DMEM between the LSU (port 0) and an auxiliary
// master (port 1). One access in flight: IDLE -> ISSUE -> RESP -> IDLE.
// Define DMEM_ARB_FAULT_CHECK_EN to enable alignment/size/range fault checking
// on the latched command; otherwise every command goes to DMEM and err is 0.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned AW    = 32,
    parameter int unsigned DEPTH = 6000
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          i_p0_req,
    input  logic          i_p0_we,
    input  logic [2:0]    i_p0_size,
    input  logic [AW-1:0] i_p0_addr,
    input  logic [31:0]   i_p0_wdata,
    output logic          o_p0_ack,
    output logic [31:0]   o_p0_rdata,
    output logic          o_p0_err,

    input  logic          i_p1_req,
    input  logic          i_p1_we,
    input  logic [2:0]    i_p1_size,
    input  logic [AW-1:0] i_p1_addr,
    input  logic [31:0]   i_p1_wdata,
    output logic          o_p1_ack,
    output logic [31:0]   o_p1_rdata,
    output logic          o_p1_err,

    output logic          o_mem_en,
    output logic          o_mem_we,
    output logic [2:0]    o_mem_size,
    output logic [AW-1:0] o_mem_addr,
    output logic [31:0]   o_mem_wdata,
    input  logic [31:0]   i_mem_rdata,

    output logic          o_busy
);

`ifdef DMEM_ARB_FAULT_CHECK_EN
    localparam logic FAULT_EN = 1'b1;
`else
    localparam logic FAULT_EN = 1'b0;
`endif

    state_t r_state;
    cmd_t   r_cmd;
    logic   r_g;
    logic   r_last_grant;

    logic        w_pick_valid;
    logic        w_pick_grant;
    cmd_t        w_p0_cmd;
    cmd_t        w_p1_cmd;
    logic        w_issue;
    logic        w_resp;
    logic        w_fault;
    logic        w_misalign;
    logic        w_illegal;
    logic        w_st_bad;
    logic        w_range;
    logic [CMD_AW:0] w_end;
    logic [31:0] w_resp_data;

    assign w_p0_cmd = '{we: i_p0_we, size: i_p0_size, addr: CMD_AW'(i_p0_addr),
                        wdata: i_p0_wdata};
    assign w_p1_cmd = '{we: i_p1_we, size: i_p1_size, addr: CMD_AW'(i_p1_addr),
                        wdata: i_p1_wdata};

    dmem_rr_pick u_pick (
        .i_req        ({i_p1_req, i_p0_req}),
        .i_last_grant (r_last_grant),
        .o_valid      (w_pick_valid),
        .o_grant      (w_pick_grant)
    );

    // FSM: latch winner's command in IDLE, then one cycle each of ISSUE and RESP.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_cmd        <= '0;
            r_g          <= 1'b0;
            r_last_grant <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pick_valid) begin
                        r_g          <= w_pick_grant;
                        r_last_grant <= w_pick_grant;
                        r_cmd        <= w_pick_grant ? w_p1_cmd : w_p0_cmd;
                        r_state      <= ISSUE;
                    end
                end
                ISSUE:   r_state <= RESP;
                RESP:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Fault check on the latched command; it stays stable through ISSUE and RESP.
    always_comb begin
        w_misalign = ((r_cmd.size == SZ_H) || (r_cmd.size == SZ_HU)) && r_cmd.addr[0];
        if ((r_cmd.size == SZ_W) && (r_cmd.addr[1:0] != 2'b00)) begin
            w_misalign = 1'b1;
        end
        w_illegal = (r_cmd.size == 3'b011) || (r_cmd.size == 3'b110) ||
                    (r_cmd.size == 3'b111);
        w_st_bad  = r_cmd.we && ((r_cmd.size == SZ_BU) || (r_cmd.size == SZ_HU));
        w_end     = {1'b0, r_cmd.addr} + {{(CMD_AW-2){1'b0}}, size_bytes(r_cmd.size)};
        w_range   = w_end > (CMD_AW+1)'(DEPTH);
        w_fault   = FAULT_EN & (w_misalign | w_illegal | w_st_bad | w_range);
    end

    // Memory command and per-port responses decoded from state and grant.
    always_comb begin
        w_issue     = (r_state == ISSUE);
        w_resp      = (r_state == RESP);
        o_busy      = (r_state != IDLE);
        o_mem_en    = w_issue && !w_fault;
        o_mem_we    = w_issue && !w_fault && r_cmd.we;
        o_mem_size  = r_cmd.size;
        o_mem_addr  = AW'(r_cmd.addr);
        o_mem_wdata = r_cmd.wdata;
        // Stores and faulted accesses return zero rather than stale DMEM data.
        w_resp_data = (w_fault || r_cmd.we) ? 32'h0 : i_mem_rdata;
        o_p0_ack    = w_resp && !r_g;
        o_p1_ack    = w_resp && r_g;
        o_p0_rdata  = o_p0_ack ? w_resp_data : 32'h0;
        o_p1_rdata  = o_p1_ack ? w_resp_data : 32'h0;
        o_p0_err    = o_p0_ack && w_fault;
        o_p1_err    = o_p1_ack && w_fault;
    end

endmodule
